alu_share_arbiter: RTL and testbench

- Shares the single ALU datapath between two requesters.
- Port 0 is the EX-stage operation issued by the pipeline; port 1 is an auxiliary unit, such as a branch compare or address-generation helper.
- Arbitrates with round-robin fairness and a valid/ready handshake, drives the ALU operation code and operands, and registers the ALU result back to the winning requester with one cycle of latency.
- Sits between the EX-stage operand muxes / ALU control and the ALU itself.

---
 rtl/alu_share_arbiter_if.sv | 53 +++++
 rtl/alu_share_arbiter.sv | 117 +++++++++++
 tb/tb_alu_share_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// Bundle of the requester, ALU and response signals around the shared ALU arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's
// view (pipeline requesters plus the ALU itself).
interface alu_share_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
);
  logic                  stall_i;
  logic                  req0_valid_i;
  logic [OP_WIDTH-1:0]   req0_op_i;
  logic [DATA_WIDTH-1:0] req0_a_i;
  logic [DATA_WIDTH-1:0] req0_b_i;
  logic                  req0_ready_o;
  logic                  req1_valid_i;
  logic [OP_WIDTH-1:0]   req1_op_i;
  logic [DATA_WIDTH-1:0] req1_a_i;
  logic [DATA_WIDTH-1:0] req1_b_i;
  logic                  req1_ready_o;
  logic [OP_WIDTH-1:0]   alu_op_o;
  logic [DATA_WIDTH-1:0] alu_a_o;
  logic [DATA_WIDTH-1:0] alu_b_o;
  logic [DATA_WIDTH-1:0] alu_result_i;
  logic                  alu_zero_i;
  logic                  rsp0_valid_o;
  logic                  rsp1_valid_o;
  logic [DATA_WIDTH-1:0] rsp_result_o;
  logic                  rsp_zero_o;
  logic [7:0]            busy_count_o;

  modport slave (
    input  stall_i,
    input  req0_valid_i, req0_op_i, req0_a_i, req0_b_i,
    output req0_ready_o,
    input  req1_valid_i, req1_op_i, req1_a_i, req1_b_i,
    output req1_ready_o,
    output alu_op_o, alu_a_o, alu_b_o,
    input  alu_result_i, alu_zero_i,
    output rsp0_valid_o, rsp1_valid_o, rsp_result_o, rsp_zero_o,
    output busy_count_o
  );

  modport master (
    output stall_i,
    output req0_valid_i, req0_op_i, req0_a_i, req0_b_i,
    input  req0_ready_o,
    output req1_valid_i, req1_op_i, req1_a_i, req1_b_i,
    input  req1_ready_o,
    input  alu_op_o, alu_a_o, alu_b_o,
    output alu_result_i, alu_zero_i,
    input  rsp0_valid_o, rsp1_valid_o, rsp_result_o, rsp_zero_o,
    input  busy_count_o
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between the EX-stage (port 0) and an auxiliary unit (port 1).
// Round-robin grant with valid/ready handshake, combinational ALU drive and a
// registered one-cycle-latency response. Also counts consecutive starved cycles.
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
) (
  input logic                clk,
  input logic                reset,
  alu_share_arbiter_if.slave bus
);

  logic                  last_grant;
  logic                  grant_valid;
  logic                  grant_sel;
  logic                  ready0;
  logic                  ready1;
  logic                  unserved;
  logic [OP_WIDTH-1:0]   alu_op;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic                  rsp0_valid;
  logic                  rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp_result;
  logic                  rsp_zero;
  logic [7:0]            busy_count;

  // Pick this cycle's winner: contested cycles go to the port that did not win last.
  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = 1'b0;
    if (reset || bus.stall_i) begin
      grant_valid = 1'b0;
      grant_sel   = 1'b0;
    end else if (bus.req0_valid_i && bus.req1_valid_i) begin
      grant_valid = 1'b1;
      grant_sel   = ~last_grant;
    end else if (bus.req0_valid_i) begin
      grant_valid = 1'b1;
      grant_sel   = 1'b0;
    end else if (bus.req1_valid_i) begin
      grant_valid = 1'b1;
      grant_sel   = 1'b1;
    end else begin
      grant_valid = 1'b0;
      grant_sel   = 1'b0;
    end
  end

  assign ready0   = grant_valid & ~grant_sel;
  assign ready1   = grant_valid &  grant_sel;
  // A valid requester that did not get the ALU this cycle is starved.
  assign unserved = (bus.req0_valid_i & ~ready0) | (bus.req1_valid_i & ~ready1);

  // Steer the winner's operation onto the ALU; idle cycles present ADD 0,0.
  always_comb begin
    alu_op = {OP_WIDTH{1'b0}};
    alu_a  = {DATA_WIDTH{1'b0}};
    alu_b  = {DATA_WIDTH{1'b0}};
    case ({ready1, ready0})
      2'b01: begin
        alu_op = bus.req0_op_i;
        alu_a  = bus.req0_a_i;
        alu_b  = bus.req0_b_i;
      end
      2'b10: begin
        alu_op = bus.req1_op_i;
        alu_a  = bus.req1_a_i;
        alu_b  = bus.req1_b_i;
      end
      default: begin
        alu_op = {OP_WIDTH{1'b0}};
        alu_a  = {DATA_WIDTH{1'b0}};
        alu_b  = {DATA_WIDTH{1'b0}};
      end
    endcase
  end

  // Capture the ALU result for the winner, remember the winner, track starvation.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_result <= {DATA_WIDTH{1'b0}};
      rsp_zero   <= 1'b0;
      busy_count <= 8'd0;
    end else begin
      rsp0_valid <= ready0;
      rsp1_valid <= ready1;
      if (grant_valid) begin
        rsp_result <= bus.alu_result_i;
        rsp_zero   <= bus.alu_zero_i;
        last_grant <= grant_sel;
      end
      if (unserved) begin
        if (busy_count != 8'hFF) begin
          busy_count <= busy_count + 8'd1;
        end
      end else begin
        busy_count <= 8'd0;
      end
    end
  end

  assign bus.req0_ready_o = ready0;
  assign bus.req1_ready_o = ready1;
  assign bus.alu_op_o     = alu_op;
  assign bus.alu_a_o      = alu_a;
  assign bus.alu_b_o      = alu_b;
  assign bus.rsp0_valid_o = rsp0_valid;
  assign bus.rsp1_valid_o = rsp1_valid;
  assign bus.rsp_result_o = rsp_result;
  assign bus.rsp_zero_o   = rsp_zero;
  assign bus.busy_count_o = busy_count;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a simple ALU stands in for the real one, a
// behavioural model predicts every output each cycle, and directed phases
// carry hand-computed expectations.
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic chk_en = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  alu_share_arbiter_if #(.DATA_WIDTH(32), .OP_WIDTH(4)) bus ();

  alu_share_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return a + b;
    endcase
  endfunction

  assign bus.alu_result_i = alu_fn(bus.alu_op_o, bus.alu_a_o, bus.alu_b_o);
  assign bus.alu_zero_i   = (bus.alu_result_i == 32'd0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: who won last, what the response registers should hold.
  int          m_last  = 1;
  bit          m_rsp0  = 1'b0;
  bit          m_rsp1  = 1'b0;
  logic [31:0] m_res   = 32'd0;
  bit          m_zero  = 1'b0;
  int          m_busy  = 0;

  // Predict outputs from the current inputs, compare, then step the model.
  always @(negedge clk) begin
    int          win;
    logic [3:0]  e_op;
    logic [31:0] e_a;
    logic [31:0] e_b;
    bit          starved;
    win  = -1;
    e_op = 4'd0;
    e_a  = 32'd0;
    e_b  = 32'd0;
    if (!reset && !bus.stall_i) begin
      if (bus.req0_valid_i && bus.req1_valid_i) win = 1 - m_last;
      else if (bus.req0_valid_i)                 win = 0;
      else if (bus.req1_valid_i)                 win = 1;
    end
    if (win == 0) begin
      e_op = bus.req0_op_i; e_a = bus.req0_a_i; e_b = bus.req0_b_i;
    end else if (win == 1) begin
      e_op = bus.req1_op_i; e_a = bus.req1_a_i; e_b = bus.req1_b_i;
    end
    if (chk_en) begin
      chk("ready0", {31'd0, bus.req0_ready_o}, {31'd0, win == 0});
      chk("ready1", {31'd0, bus.req1_ready_o}, {31'd0, win == 1});
      chk("alu_op", {28'd0, bus.alu_op_o}, {28'd0, e_op});
      chk("alu_a", bus.alu_a_o, e_a);
      chk("alu_b", bus.alu_b_o, e_b);
      chk("rsp0_valid", {31'd0, bus.rsp0_valid_o}, {31'd0, m_rsp0});
      chk("rsp1_valid", {31'd0, bus.rsp1_valid_o}, {31'd0, m_rsp1});
      chk("rsp_result", bus.rsp_result_o, m_res);
      chk("rsp_zero", {31'd0, bus.rsp_zero_o}, {31'd0, m_zero});
      chk("busy_count", {24'd0, bus.busy_count_o}, m_busy);
    end
    if (reset) begin
      m_last = 1; m_rsp0 = 1'b0; m_rsp1 = 1'b0;
      m_res  = 32'd0; m_zero = 1'b0; m_busy = 0;
    end else begin
      m_rsp0 = (win == 0);
      m_rsp1 = (win == 1);
      if (win >= 0) begin
        m_res  = alu_fn(e_op, e_a, e_b);
        m_zero = (m_res == 32'd0);
        m_last = win;
      end
      starved = (bus.req0_valid_i && win != 0) || (bus.req1_valid_i && win != 1);
      m_busy  = starved ? ((m_busy < 255) ? m_busy + 1 : 255) : 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] pat0;
    pat0 = 6'b010101;
    reset = 1'b1;
    bus.stall_i = 1'b0;
    bus.req0_valid_i = 1'b0; bus.req0_op_i = 4'd0; bus.req0_a_i = 32'd0; bus.req0_b_i = 32'd0;
    bus.req1_valid_i = 1'b0; bus.req1_op_i = 4'd0; bus.req1_a_i = 32'd0; bus.req1_b_i = 32'd0;
    step();
    step();
    chk_en = 1'b1;
    chk("rst_rsp0", {31'd0, bus.rsp0_valid_o}, 32'd0);
    chk("rst_busy", {24'd0, bus.busy_count_o}, 32'd0);
    reset = 1'b0;

    // Single requester: ADD 5+7.
    bus.req0_valid_i = 1'b1; bus.req0_op_i = 4'd0; bus.req0_a_i = 32'd5; bus.req0_b_i = 32'd7;
    #2;
    chk("t1_ready0", {31'd0, bus.req0_ready_o}, 32'd1);
    chk("t1_ready1", {31'd0, bus.req1_ready_o}, 32'd0);
    step();
    chk("t1_rsp0", {31'd0, bus.rsp0_valid_o}, 32'd1);
    chk("t1_rsp1", {31'd0, bus.rsp1_valid_o}, 32'd0);
    chk("t1_result", bus.rsp_result_o, 32'd12);
    chk("t1_zero", {31'd0, bus.rsp_zero_o}, 32'd0);
    bus.req0_valid_i = 1'b0;
    step();
    chk("idle_rsp0", {31'd0, bus.rsp0_valid_o}, 32'd0);
    chk("idle_hold", bus.rsp_result_o, 32'd12);

    // Reset so continuous contention starts from last_grant = 1.
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.req0_valid_i = 1'b1; bus.req0_op_i = 4'd1; bus.req0_a_i = 32'd9;    bus.req0_b_i = 32'd9;
    bus.req1_valid_i = 1'b1; bus.req1_op_i = 4'd2; bus.req1_a_i = 32'h0F0; bus.req1_b_i = 32'h00F;
    for (int i = 0; i < 6; i++) begin
      #2;
      chk("t2_ready0", {31'd0, bus.req0_ready_o}, {31'd0, pat0[i]});
      step();
      chk("t2_rsp0", {31'd0, bus.rsp0_valid_o}, {31'd0, pat0[i]});
      chk("t2_result", bus.rsp_result_o, 32'd0);
      chk("t2_zero", {31'd0, bus.rsp_zero_o}, 32'd1);
    end

    // Idle one cycle to clear the starvation count, then stall with both valid.
    bus.req0_valid_i = 1'b0; bus.req1_valid_i = 1'b0;
    step();
    bus.req0_valid_i = 1'b1; bus.req0_op_i = 4'd0; bus.req0_a_i = 32'd2; bus.req0_b_i = 32'd3;
    bus.req1_valid_i = 1'b1; bus.req1_op_i = 4'd4; bus.req1_a_i = 32'd6; bus.req1_b_i = 32'd6;
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("t3_noready", {30'd0, bus.req1_ready_o, bus.req0_ready_o}, 32'd0);
      chk("t3_alu_a", bus.alu_a_o, 32'd0);
      step();
    end
    chk("t3_busy3", {24'd0, bus.busy_count_o}, 32'd3);
    bus.stall_i = 1'b0;
    #2;
    chk("t3_resume0", {31'd0, bus.req0_ready_o}, 32'd1);
    step();
    chk("t3_busy4", {24'd0, bus.busy_count_o}, 32'd4);
    chk("t3_res", bus.rsp_result_o, 32'd5);
    bus.req0_valid_i = 1'b0;
    step();
    chk("t3_busy0", {24'd0, bus.busy_count_o}, 32'd0);
    chk("t3_rsp1", {31'd0, bus.rsp1_valid_o}, 32'd1);
    chk("t3_zero", {31'd0, bus.rsp_zero_o}, 32'd1);
    bus.req1_valid_i = 1'b0;
    step();

    // req1 OR 3|4, then reset in the following cycle.
    bus.req1_valid_i = 1'b1; bus.req1_op_i = 4'd3; bus.req1_a_i = 32'd3; bus.req1_b_i = 32'd4;
    #2;
    chk("t4_ready1", {31'd0, bus.req1_ready_o}, 32'd1);
    chk("t4_alu_op", {28'd0, bus.alu_op_o}, 32'd3);
    step();
    bus.req1_valid_i = 1'b0;
    reset = 1'b1;
    chk("t4_pre_rsp1", {31'd0, bus.rsp1_valid_o}, 32'd1);
    chk("t4_pre_res", bus.rsp_result_o, 32'd7);
    step();
    chk("t4_rsp1_sup", {31'd0, bus.rsp1_valid_o}, 32'd0);
    chk("t4_res_clr", bus.rsp_result_o, 32'd0);
    reset = 1'b0;
    bus.req0_valid_i = 1'b1; bus.req0_op_i = 4'd0; bus.req0_a_i = 32'd1; bus.req0_b_i = 32'd1;
    bus.req1_valid_i = 1'b1; bus.req1_op_i = 4'd0; bus.req1_a_i = 32'd2; bus.req1_b_i = 32'd2;
    #2;
    chk("t4_ready0", {31'd0, bus.req0_ready_o}, 32'd1);
    step();
    bus.req0_valid_i = 1'b0; bus.req1_valid_i = 1'b0;
    step();

    // Long stall: starvation count saturates at 255.
    bus.req0_valid_i = 1'b1; bus.req0_op_i = 4'd9; bus.req0_a_i = 32'd1; bus.req0_b_i = 32'd1;
    bus.stall_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 253) chk("t5_busy254", {24'd0, bus.busy_count_o}, 32'd254);
    end
    chk("t5_busy255", {24'd0, bus.busy_count_o}, 32'd255);
    chk("t5_noready", {31'd0, bus.req0_ready_o}, 32'd0);
    bus.stall_i = 1'b0;
    #2;
    chk("t5_op_pass", {28'd0, bus.alu_op_o}, 32'd9);
    step();
    bus.req0_valid_i = 1'b0;
    step();
    chk("t5_busy_clr", {24'd0, bus.busy_count_o}, 32'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
